axis_fifo_pkt: RTL and testbench

- Synchronous AXI-Stream FIFO: successor to the simple FIFO in the UART TX/RX data paths.
- Full valid/ready handshake on both sides; first-word-fall-through output.
- Simultaneous push and pop in the same cycle; level and threshold flags.
- Optional packet mode: holds output until a complete tlast-terminated frame is stored, so the UART TX never starves mid-frame.

---
 rtl/axis_fifo_pkt.sv | 157 +++++++++++++++
 tb/tb_axis_fifo_pkt.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_pkt.sv
`default_nettype none
// ============================================================================
//  Module   : axis_fifo_pkt
//  Brief    : Synchronous AXI-Stream FIFO with first-word-fall-through output,
//             level / threshold flags and optional store-and-forward packet
//             mode with an oversized-frame flush escape.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_fifo_pkt #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int ALMOST_FULL  = 14,
  parameter int ALMOST_EMPTY = 2,
  parameter int PACKET_MODE  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     almost_full,
  output logic                     almost_empty
);

  localparam int          AW     = $clog2(DEPTH);
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_AF   = (AW+1)'(ALMOST_FULL);
  localparam logic [AW:0] C_AE   = (AW+1)'(ALMOST_EMPTY);

  // Each entry carries {tlast, tdata}.
  logic [DATA_WIDTH:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_level;

  logic                w_push;
  logic                w_pop;
  logic                w_out_valid;
  logic [DATA_WIDTH:0] w_rd_word;

  // Ready is held low in reset and whenever full, even if a pop is in flight.
  assign s_axis_tready = rst_n & (r_level != C_FULL);
  assign w_push        = s_axis_tvalid & s_axis_tready;
  assign w_pop         = w_out_valid & m_axis_tready;

  // First-word-fall-through: head entry is presented combinationally.
  assign w_rd_word     = r_mem[r_rd_ptr];
  assign m_axis_tdata  = w_rd_word[DATA_WIDTH-1:0];
  assign m_axis_tlast  = w_rd_word[DATA_WIDTH];
  assign m_axis_tvalid = w_out_valid;

  assign level         = r_level;
  assign almost_full   = (r_level >= C_AF);
  assign almost_empty  = (r_level <= C_AE);

  // Storage write on each accepted beat; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // Pointers wrap naturally; level tracks push/pop, unchanged when both occur.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  generate
    if (PACKET_MODE != 0) begin : g_packet
      typedef enum logic [0:0] {
        ST_HOLD  = 1'b0,
        ST_FLUSH = 1'b1
      } state_t;

      state_t      r_state;
      state_t      w_state_next;
      logic        w_valid;
      logic [AW:0] r_pkt_cnt;
      logic        w_pkt_in;
      logic        w_pkt_out;

      // A stored frame is complete once its tlast beat is accepted; the
      // count never goes below zero even if a tlast pops in flush.
      assign w_pkt_in  = w_push & s_axis_tlast;
      assign w_pkt_out = w_pop & m_axis_tlast & (r_pkt_cnt != '0);

      // Complete-packet counter and hold/flush state register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_state   <= ST_HOLD;
          r_pkt_cnt <= '0;
        end else begin
          r_state <= w_state_next;
          case ({w_pkt_in, w_pkt_out})
            2'b10:   r_pkt_cnt <= r_pkt_cnt + (AW+1)'(1);
            2'b01:   r_pkt_cnt <= r_pkt_cnt - (AW+1)'(1);
            default: r_pkt_cnt <= r_pkt_cnt;
          endcase
        end
      end

      // Hold output until a whole frame is stored; a frame that fills the
      // FIFO without a tlast can never complete, so stream it out instead.
      always_comb begin
        w_state_next = r_state;
        w_valid      = 1'b0;
        case (r_state)
          ST_HOLD: begin
            w_valid = (r_pkt_cnt != '0);
            if ((r_level == C_FULL) && (r_pkt_cnt == '0)) begin
              w_state_next = ST_FLUSH;
            end
          end
          ST_FLUSH: begin
            w_valid = (r_level != '0);
            // Valid equals (level != 0) here, so this is the tlast pop.
            if (m_axis_tready && m_axis_tlast && (r_level != '0)) begin
              w_state_next = ST_HOLD;
            end
          end
          default: begin
            w_state_next = ST_HOLD;
            w_valid      = 1'b0;
          end
        endcase
      end

      assign w_out_valid = w_valid;
    end else begin : g_stream
      assign w_out_valid = (r_level != '0);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axis_fifo_pkt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_fifo_pkt
//  Brief    : Self-checking bench for axis_fifo_pkt; one stream-mode and one
//             packet-mode instance, each with a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_fifo_pkt;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  // Stream-mode instance signals
  logic [DW-1:0] st_sd, st_md;
  logic          st_sl, st_sv, st_sr, st_ml, st_mv, st_mr, st_af, st_ae;
  logic [4:0]    st_lvl;
  // Packet-mode instance signals
  logic [DW-1:0] pk_sd, pk_md;
  logic          pk_sl, pk_sv, pk_sr, pk_ml, pk_mv, pk_mr, pk_af, pk_ae;
  logic [4:0]    pk_lvl;

  axis_fifo_pkt #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE), .PACKET_MODE(0)
  ) u_stream (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(st_sd), .s_axis_tlast(st_sl), .s_axis_tvalid(st_sv), .s_axis_tready(st_sr),
    .m_axis_tdata(st_md), .m_axis_tlast(st_ml), .m_axis_tvalid(st_mv), .m_axis_tready(st_mr),
    .level(st_lvl), .almost_full(st_af), .almost_empty(st_ae)
  );

  axis_fifo_pkt #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL(AF), .ALMOST_EMPTY(AE), .PACKET_MODE(1)
  ) u_packet (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(pk_sd), .s_axis_tlast(pk_sl), .s_axis_tvalid(pk_sv), .s_axis_tready(pk_sr),
    .m_axis_tdata(pk_md), .m_axis_tlast(pk_ml), .m_axis_tvalid(pk_mv), .m_axis_tready(pk_mr),
    .level(pk_lvl), .almost_full(pk_af), .almost_empty(pk_ae)
  );

  int checks = 0;
  int errors = 0;

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- stream-mode reference model + monitor ----------------
  logic [DW:0] sq[$];
  logic        st_ev, st_pop, st_push;

  always @(negedge clk) begin
    if (!rst_n) begin
      sq.delete();
      cmp("st_rst_tready", int'(st_sr), 0);
      cmp("st_rst_tvalid", int'(st_mv), 0);
      cmp("st_rst_level",  int'(st_lvl), 0);
      cmp("st_rst_aempty", int'(st_ae), 1);
    end else begin
      st_ev = (sq.size() != 0);
      cmp("st_tready", int'(st_sr),  int'(sq.size() != DEPTH));
      cmp("st_tvalid", int'(st_mv),  int'(st_ev));
      cmp("st_level",  int'(st_lvl), sq.size());
      cmp("st_afull",  int'(st_af),  int'(sq.size() >= AF));
      cmp("st_aempty", int'(st_ae),  int'(sq.size() <= AE));
      st_pop  = st_ev && st_mr;
      st_push = st_sv && (sq.size() != DEPTH);
      if (st_pop) begin
        cmp("st_tdata", int'(st_md), int'(sq[0][DW-1:0]));
        cmp("st_tlast", int'(st_ml), int'(sq[0][DW]));
        void'(sq.pop_front());
      end
      if (st_push) sq.push_back({st_sl, st_sd});
    end
  end

  // ---------------- packet-mode reference model + monitor ----------------
  // Output is offered when the queue holds a complete frame, or while
  // flushing a frame that filled the whole FIFO without a tlast.
  logic [DW:0] pq[$];
  int          pk_nlast = 0;
  logic        pk_flush = 1'b0;
  logic        pk_fnext, pk_ev, pk_pop, pk_push;

  always @(negedge clk) begin
    if (!rst_n) begin
      pq.delete();
      pk_nlast = 0;
      pk_flush = 1'b0;
      cmp("pk_rst_tready", int'(pk_sr), 0);
      cmp("pk_rst_tvalid", int'(pk_mv), 0);
      cmp("pk_rst_level",  int'(pk_lvl), 0);
      cmp("pk_rst_aempty", int'(pk_ae), 1);
    end else begin
      pk_ev = pk_flush ? (pq.size() != 0) : (pk_nlast != 0);
      cmp("pk_tready", int'(pk_sr),  int'(pq.size() != DEPTH));
      cmp("pk_tvalid", int'(pk_mv),  int'(pk_ev));
      cmp("pk_level",  int'(pk_lvl), pq.size());
      cmp("pk_afull",  int'(pk_af),  int'(pq.size() >= AF));
      cmp("pk_aempty", int'(pk_ae),  int'(pq.size() <= AE));
      pk_pop   = pk_ev && pk_mr;
      pk_push  = pk_sv && (pq.size() != DEPTH);
      pk_fnext = pk_flush;
      if (!pk_flush && pq.size() == DEPTH && pk_nlast == 0) pk_fnext = 1'b1;
      if (pk_pop) begin
        cmp("pk_tdata", int'(pk_md), int'(pq[0][DW-1:0]));
        cmp("pk_tlast", int'(pk_ml), int'(pq[0][DW]));
        if (pq[0][DW]) begin
          pk_nlast--;
          if (pk_flush) pk_fnext = 1'b0;
        end
        void'(pq.pop_front());
      end
      if (pk_push) begin
        pq.push_back({pk_sl, pk_sd});
        if (pk_sl) pk_nlast++;
      end
      pk_flush = pk_fnext;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic st_beat(input logic [DW-1:0] d, input logic l);
    st_sv = 1'b1; st_sd = d; st_sl = l;
    cyc(1);
    st_sv = 1'b0;
  endtask

  task automatic pk_beat(input logic [DW-1:0] d, input logic l);
    pk_sv = 1'b1; pk_sd = d; pk_sl = l;
    cyc(1);
    pk_sv = 1'b0;
  endtask

  initial begin
    st_sd = '0; st_sl = 1'b0; st_sv = 1'b0; st_mr = 1'b0;
    pk_sd = '0; pk_sl = 1'b0; pk_sv = 1'b0; pk_mr = 1'b0;
    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    // Stream: fill to full, attempt an extra beat, drain; repeat for wrap.
    for (int i = 0; i < 16; i++) st_beat(8'(i), i == 15);
    st_sv = 1'b1; st_sd = 8'h10; cyc(2); st_sv = 1'b0;
    st_mr = 1'b1; cyc(18); st_mr = 1'b0;
    for (int i = 0; i < 16; i++) st_beat(8'(8'h40 + i), 1'b0);
    st_mr = 1'b1; cyc(18); st_mr = 1'b0;

    // Stream: level 5 then push and pop together for 40 cycles.
    for (int i = 0; i < 5; i++) st_beat(8'(8'h60 + i), 1'b0);
    st_mr = 1'b1;
    for (int i = 0; i < 40; i++) begin
      st_sv = 1'b1; st_sd = 8'(8'h80 + i); st_sl = (i % 7 == 0);
      cyc(1);
    end
    st_sv = 1'b0; cyc(8); st_mr = 1'b0;

    // Stream: at full, push+pop together pops only; push accepted next cycle.
    for (int i = 0; i < 16; i++) st_beat(8'(8'hC0 + i), 1'b0);
    st_sv = 1'b1; st_sd = 8'hEE; st_sl = 1'b1; st_mr = 1'b1; cyc(1);
    st_mr = 1'b0; cyc(1);
    st_sv = 1'b0; st_mr = 1'b1; cyc(20); st_mr = 1'b0;

    // Packet: 3-beat frame with gaps is held until its tlast is stored.
    pk_mr = 1'b1;
    pk_beat(8'hA1, 1'b0); cyc(2);
    pk_beat(8'hA2, 1'b0); cyc(2);
    pk_beat(8'hA3, 1'b1); cyc(6);

    // Packet: oversized frame fills the FIFO, flushes, then normal hold.
    pk_mr = 1'b0;
    for (int i = 0; i < 16; i++) pk_beat(8'(8'hB0 + i), 1'b0);
    cyc(2);
    pk_mr = 1'b1; cyc(18);
    pk_beat(8'hBF, 1'b1); cyc(3);
    pk_beat(8'hD0, 1'b0); cyc(3);
    pk_beat(8'hD1, 1'b1); cyc(4);

    // Randomised traffic on both instances, with a mid-traffic reset.
    for (int c = 0; c < 2400; c++) begin
      if (c == 1200) begin
        rst_n = 1'b0; cyc(2); rst_n = 1'b1;
      end
      st_sv = ($urandom_range(0, 3) != 0);
      st_sd = 8'($urandom);
      st_sl = 1'($urandom);
      st_mr = ((c % 200) < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      pk_sv = ($urandom_range(0, 3) != 0);
      pk_sd = 8'($urandom);
      pk_sl = ((c % 600) < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 40) == 0);
      pk_mr = ((c % 300) < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc(1);
    end
    st_sv = 1'b0; pk_sv = 1'b0;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
